// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus ALU operand/result bus between fetch, sequencer and the 20-bit ALU.
// master = the sequencer side; slave = the fetch/ALU environment.
interface alu_sequencer_if #(parameter int WORD_W = 20);
  logic              instr_valid;
  logic              instr_ready;
  logic [19:0]       instr;
  logic [4:0]        alu_op;
  logic              alu_mode;
  logic [WORD_W-1:0] alu_a;
  logic [WORD_W-1:0] alu_b;
  logic              alu_cin;
  logic [WORD_W-1:0] alu_c;
  logic [WORD_W-1:0] alu_c2;
  logic              alu_zero;
  logic              alu_sign;
  logic              alu_carry;

  modport master (
    input  instr_valid, instr, alu_c, alu_c2, alu_zero, alu_sign, alu_carry,
    output instr_ready, alu_op, alu_mode, alu_a, alu_b, alu_cin
  );

  modport slave (
    output instr_valid, instr, alu_c, alu_c2, alu_zero, alu_sign, alu_carry,
    input  instr_ready, alu_op, alu_mode, alu_a, alu_b, alu_cin
  );
endinterface

// File: rtl/alu_sequencer.sv
// Sequencer for the 20-bit ALU: IDLE -> READ -> EXEC -> WB, 8x20 register file, {S,Z,C} status,
// PC with jumps, and an absorbing TRAP state for op 1 and illegal ops 28-31.
module alu_sequencer #(
  parameter int WORD_W = 20,
  parameter int PC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_sequencer_if.master    bus,
  output logic [2:0]         status,
  output logic [PC_W-1:0]    pc,
  output logic               busy,
  output logic               trap,
  input  logic [2:0]         dbg_addr,
  output logic [WORD_W-1:0]  dbg_data
);
  typedef struct packed {
    logic [4:0] op;
    logic       mode;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm;
  } instr_t;

  localparam logic [2:0] S_IDLE = 3'd0, S_READ = 3'd1, S_EXEC = 3'd2, S_WB = 3'd3, S_TRAP = 3'd4;

  localparam logic [4:0] OP_TRAP = 5'd1,  OP_JMP = 5'd2,  OP_JZ  = 5'd3,  OP_JS  = 5'd4,
                         OP_JZS  = 5'd5,  OP_LSR = 5'd6,  OP_XSR = 5'd7,  OP_SWAP = 5'd16,
                         OP_ADC  = 5'd20, OP_SBC = 5'd22, OP_LE  = 5'd27;

  logic [2:0]        state_q, state_d;
  instr_t            ir_q;
  logic [WORD_W-1:0] opa_q, opb_q, res_q, res2_q;
  logic [2:0]        flg_q;
  logic [WORD_W-1:0] regs_q [8];
  logic [2:0]        status_q, status_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              trap_q, trap_d;
  logic              we_rd, we_rs, jtaken;
  logic              is_trap, is_flow, wr_rd, set_flg, exec;

  assign is_trap = (ir_q.op == OP_TRAP) || (ir_q.op >= 5'd28);
  assign is_flow = ir_q.op <= OP_XSR;
  assign wr_rd   = (ir_q.op >= 5'd8) && (ir_q.op <= OP_SBC);
  assign set_flg = (ir_q.op >= 5'd8) && (ir_q.op <= OP_LE);
  assign exec    = state_q == S_EXEC;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    status_d = status_q;
    trap_d   = trap_q;
    we_rd    = 1'b0;
    we_rs    = 1'b0;
    jtaken   = 1'b0;
    case (state_q)
      S_IDLE: if (bus.instr_valid) state_d = S_READ;
      S_READ: state_d = (is_flow || is_trap) ? S_WB : S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
        if (is_trap) begin
          // pc, regs and status stay frozen; only reset leaves this state
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
          case (ir_q.op)
            OP_JMP: jtaken = 1'b1;
            OP_JZ:  jtaken = status_q[1];
            OP_JS:  jtaken = status_q[2];
            OP_JZS: jtaken = status_q[2] | status_q[1];
            OP_LSR: status_d = ir_q.imm[2:0];
            OP_XSR: status_d = status_q ^ ir_q.imm[2:0];
            default: if (set_flg) status_d = flg_q;
          endcase
          pc_d  = jtaken ? PC_W'(ir_q.imm) : pc_q + PC_W'(1);
          we_rd = wr_rd;
          we_rs = wr_rd && (ir_q.op == OP_SWAP) && (ir_q.rd != ir_q.rs);
        end
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      res2_q   <= '0;
      flg_q    <= '0;
      status_q <= '0;
      pc_q     <= '0;
      trap_q   <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      status_q <= status_d;
      trap_q   <= trap_d;
      if (state_q == S_IDLE && bus.instr_valid) ir_q <= instr_t'(bus.instr);
      if (state_q == S_READ) begin
        opa_q <= regs_q[ir_q.rd];
        opb_q <= regs_q[ir_q.rs];
      end
      if (exec) begin
        res_q  <= bus.alu_c;
        res2_q <= bus.alu_c2;
        flg_q  <= {bus.alu_sign, bus.alu_zero, bus.alu_carry};
      end
      // rd is written after rs so that SWAP with rd==rs keeps the primary result
      if (we_rs) regs_q[ir_q.rs] <= res2_q;
      if (we_rd) regs_q[ir_q.rd] <= res_q;
    end
  end

  assign bus.instr_ready = state_q == S_IDLE;
  assign bus.alu_op      = exec ? ir_q.op : '0;
  assign bus.alu_mode    = exec & ir_q.mode;
  assign bus.alu_a       = exec ? opa_q : '0;
  assign bus.alu_b       = exec ? opb_q : '0;
  assign bus.alu_cin     = exec && (ir_q.op == OP_ADC || ir_q.op == OP_SBC) && status_q[0];

  assign status   = status_q;
  assign pc       = pc_q;
  assign busy     = state_q != S_IDLE;
  assign trap     = trap_q;
  assign dbg_data = regs_q[dbg_addr];
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a behavioural ALU answers EXEC cycles; expected completions are
// queued at issue time and a monitor compares pc/status/trap/registers whenever an instruction retires.
module tb_alu_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_sequencer_if bus();
  logic [2:0]  status;
  logic [7:0]  pc;
  logic        busy, trap;
  logic [2:0]  dbg_addr, stim_addr, mon_addr;
  logic        mon_active;
  logic [19:0] dbg_data;

  assign dbg_addr = mon_active ? mon_addr : stim_addr;

  alu_sequencer #(.WORD_W(20), .PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .status(status), .pc(pc), .busy(busy),
    .trap(trap), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // behavioural ALU: half mode works on the low 10 bits
  logic [19:0] am, aa, ab, ac, ac2;
  logic [20:0] as;
  logic        acy;
  always_comb begin
    am  = bus.alu_mode ? 20'hFFFFF : 20'h003FF;
    aa  = bus.alu_a & am;
    ab  = bus.alu_b & am;
    as  = '0;
    ac2 = '0;
    case (bus.alu_op)
      5'd8:  as = {1'b0, ~aa};
      5'd9:  as = {1'b0, aa & ab};
      5'd10: as = {1'b0, aa | ab};
      5'd11: as = {1'b0, aa ^ ab};
      5'd12: as = {1'b0, aa >> 1};
      5'd13: as = {1'b0, aa << 1};
      5'd14: as = {1'b0, bus.alu_mode ? {aa[0], aa[19:1]} : {10'd0, aa[0], aa[9:1]}};
      5'd15: as = {1'b0, bus.alu_mode ? {aa[18:0], aa[19]} : {10'd0, aa[8:0], aa[9]}};
      5'd16: begin as = {1'b0, ab}; ac2 = aa; end
      5'd17: as = {1'b0, aa} + 21'd1;
      5'd18: as = {1'b0, aa} - 21'd1;
      5'd19: as = {1'b0, aa} + {1'b0, ab};
      5'd20: as = {1'b0, aa} + {1'b0, ab} + {20'd0, bus.alu_cin};
      5'd21: as = {1'b0, aa} - {1'b0, ab};
      5'd22: as = {1'b0, aa} - {1'b0, ab} - {20'd0, bus.alu_cin};
      5'd23: as = {20'd0, aa == ab};
      5'd24: as = {20'd0, aa > ab};
      5'd25: as = {20'd0, aa < ab};
      5'd26: as = {20'd0, aa >= ab};
      5'd27: as = {20'd0, aa <= ab};
      default: as = '0;
    endcase
    ac  = as[19:0] & am;
    acy = (bus.alu_op >= 5'd17 && bus.alu_op <= 5'd22) ? (bus.alu_mode ? as[20] : as[10]) : 1'b0;
  end
  assign bus.alu_c     = ac;
  assign bus.alu_c2    = ac2;
  assign bus.alu_zero  = (ac == 20'd0);
  assign bus.alu_sign  = bus.alu_mode ? ac[19] : ac[9];
  assign bus.alu_carry = acy;

  typedef struct {
    logic [7:0]  pc;
    logic [2:0]  st;
    logic        tr;
    logic [2:0]  ra;
    logic [19:0] da;
    logic [2:0]  rb;
    logic [19:0] db;
  } exp_t;
  exp_t q[$];

  int passed = 0;
  int total  = 0;
  int busy_cyc, exec_cyc;
  logic last_cin, last_mode;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    total++;
    $display("FAIL %s: bound expired", nm);
  endtask

  function automatic logic [19:0] enc(input logic [4:0] op, input logic m, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [7:0] imm);
    return {op, m, rd, rs, imm};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.instr_ready) fail_now("ready_wait");
  endtask

  task automatic issue(input logic [19:0] w, input logic [7:0] epc, input logic [2:0] est,
                       input logic etr, input logic [2:0] ra, input logic [19:0] da,
                       input logic [2:0] rb, input logic [19:0] db);
    exp_t e;
    int n;
    wait_ready();
    e.pc = epc; e.st = est; e.tr = etr; e.ra = ra; e.da = da; e.rb = rb; e.db = db;
    q.push_back(e);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    busy_cyc = 0; exec_cyc = 0; last_cin = 1'b0; last_mode = 1'b0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) busy_cyc++;
      if (bus.alu_op != 5'd0) begin exec_cyc++; last_cin = bus.alu_cin; last_mode = bus.alu_mode; end
    end while (busy && !trap && n < 20);
    if (busy && !trap) fail_now("retire_wait");
  endtask

  // monitor: an instruction retires when busy falls or trap rises
  initial begin
    logic pb, pt, b, t;
    exp_t e;
    pb = 1'b0; pt = 1'b0; mon_active = 1'b0; mon_addr = '0;
    forever begin
      @(negedge clk);
      b = busy; t = trap;
      if (!rst_n) begin
        pb = 1'b0; pt = 1'b0;
      end else begin
        if ((pb && !b) || (!pt && t)) begin
          if (q.size() == 0) fail_now("unexpected_retire");
          else begin
            e = q.pop_front();
            chk("pc", 32'(pc), 32'(e.pc));
            chk("status", 32'(status), 32'(e.st));
            chk("trap", 32'(trap), 32'(e.tr));
            mon_active = 1'b1;
            mon_addr = e.ra;
            #1 chk($sformatf("R%0d", e.ra), 32'(dbg_data), 32'(e.da));
            mon_addr = e.rb;
            #1 chk($sformatf("R%0d", e.rb), 32'(dbg_data), 32'(e.db));
            mon_active = 1'b0;
          end
        end
        pb = b; pt = t;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ep;
    int cnt;
    rst_n = 1'b0; bus.instr_valid = 1'b0; bus.instr = '0; stim_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_status", 32'(status), 0);
    chk("rst_trap", 32'(trap), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(bus.instr_ready), 1);
    chk("rst_alu_op", 32'(bus.alu_op), 0);
    chk("rst_alu_a", 32'(bus.alu_a), 0);
    for (int r = 0; r < 8; r++) begin
      stim_addr = 3'(r);
      #1 chk("rst_reg", 32'(dbg_data), 0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);

    ep = 8'd0;
    for (int i = 1; i <= 15; i++) begin
      ep = ep + 8'd1;
      issue(enc(5'd17, 1'b1, 3'd1, 3'd0, 8'd0), ep, 3'd0, 1'b0, 3'd1, 20'(i), 3'd1, 20'(i));
    end
    for (int i = 1; i <= 15; i++) begin
      ep = ep + 8'd1;
      issue(enc(5'd17, 1'b1, 3'd2, 3'd0, 8'd0), ep, 3'd0, 1'b0, 3'd2, 20'(i), 3'd2, 20'(i));
    end
    for (int k = 1; k <= 4; k++) begin
      ep = ep + 8'd1;
      issue(enc(5'd13, 1'b1, 3'd2, 3'd0, 8'd0), ep, 3'd0, 1'b0, 3'd2, 20'h0000F << k, 3'd2, 20'h0000F << k);
    end
    issue(enc(5'd10, 1'b1, 3'd1, 3'd2, 8'd0), 8'd35, 3'd0, 1'b0, 3'd1, 20'h000FF, 3'd2, 20'h000F0);
    chk("or_mode", 32'(last_mode), 1);
    issue(enc(5'd18, 1'b1, 3'd5, 3'd0, 8'd0), 8'd36, 3'd5, 1'b0, 3'd5, 20'hFFFFF, 3'd5, 20'hFFFFF);
    for (int k = 1; k <= 10; k++)
      issue(enc(5'd13, 1'b1, 3'd5, 3'd0, 8'd0), 8'(36 + k), 3'd4, 1'b0, 3'd5, 20'hFFFFF << k, 3'd5, 20'hFFFFF << k);
    issue(enc(5'd9, 1'b0, 3'd5, 3'd5, 8'd0), 8'd47, 3'd2, 1'b0, 3'd5, 20'h00000, 3'd1, 20'h000FF);
    chk("and_half_mode", 32'(last_mode), 0);
    issue(enc(5'd3, 1'b0, 3'd0, 3'd0, 8'h40), 8'h40, 3'd2, 1'b0, 3'd5, 20'h00000, 3'd2, 20'h000F0);
    chk("jz_busy_cycles", 32'(busy_cyc), 2);
    chk("jz_exec_cycles", 32'(exec_cyc), 0);

    for (int i = 1; i <= 5; i++)
      issue(enc(5'd17, 1'b1, 3'd3, 3'd0, 8'd0), 8'(8'h40 + i), 3'd0, 1'b0, 3'd3, 20'(i), 3'd3, 20'(i));
    for (int i = 1; i <= 9; i++)
      issue(enc(5'd17, 1'b1, 3'd4, 3'd0, 8'd0), 8'(8'h45 + i), 3'd0, 1'b0, 3'd4, 20'(i), 3'd4, 20'(i));
    issue(enc(5'd16, 1'b1, 3'd3, 3'd4, 8'd0), 8'h4F, 3'd0, 1'b0, 3'd3, 20'd9, 3'd4, 20'd5);
    chk("swap_busy_cycles", 32'(busy_cyc), 3);
    chk("swap_cin", 32'(last_cin), 0);
    issue(enc(5'd4, 1'b0, 3'd0, 3'd0, 8'h10), 8'h50, 3'd0, 1'b0, 3'd3, 20'd9, 3'd4, 20'd5);
    issue(enc(5'd6, 1'b0, 3'd0, 3'd0, 8'h05), 8'h51, 3'd5, 1'b0, 3'd1, 20'h000FF, 3'd2, 20'h000F0);
    issue(enc(5'd7, 1'b0, 3'd0, 3'd0, 8'h07), 8'h52, 3'd2, 1'b0, 3'd1, 20'h000FF, 3'd2, 20'h000F0);
    issue(enc(5'd5, 1'b0, 3'd0, 3'd0, 8'h80), 8'h80, 3'd2, 1'b0, 3'd1, 20'h000FF, 3'd2, 20'h000F0);

    issue(enc(5'd18, 1'b1, 3'd5, 3'd0, 8'd0), 8'h81, 3'd5, 1'b0, 3'd5, 20'hFFFFF, 3'd5, 20'hFFFFF);
    issue(enc(5'd17, 1'b1, 3'd5, 3'd0, 8'd0), 8'h82, 3'd3, 1'b0, 3'd5, 20'h00000, 3'd5, 20'h00000);
    issue(enc(5'd20, 1'b1, 3'd1, 3'd2, 8'd0), 8'h83, 3'd0, 1'b0, 3'd1, 20'h001F0, 3'd2, 20'h000F0);
    chk("adc_cin", 32'(last_cin), 1);
    chk("adc_exec_cycles", 32'(exec_cyc), 1);
    chk("adc_busy_cycles", 32'(busy_cyc), 3);
    issue(enc(5'd2, 1'b0, 3'd0, 3'd0, 8'hFF), 8'hFF, 3'd0, 1'b0, 3'd1, 20'h001F0, 3'd3, 20'd9);
    issue(enc(5'd0, 1'b0, 3'd0, 3'd0, 8'h00), 8'h00, 3'd0, 1'b0, 3'd1, 20'h001F0, 3'd4, 20'd5);

    issue(enc(5'd31, 1'b1, 3'd1, 3'd2, 8'h12), 8'h00, 3'd0, 1'b1, 3'd1, 20'h001F0, 3'd2, 20'h000F0);
    bus.instr_valid = 1'b1;
    bus.instr = enc(5'd17, 1'b1, 3'd1, 3'd0, 8'd0);
    cnt = 0;
    repeat (100) begin @(negedge clk); if (bus.instr_ready) cnt++; end
    chk("trap_ready_high_cycles", 32'(cnt), 0);
    chk("trap_sticky", 32'(trap), 1);
    chk("trap_pc", 32'(pc), 0);
    bus.instr_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_trap_ready", 32'(bus.instr_ready), 1);
    chk("post_trap_trap", 32'(trap), 0);
    chk("post_trap_busy", 32'(busy), 0);
    for (int r = 0; r < 8; r++) begin
      stim_addr = 3'(r);
      #1 chk("post_trap_reg", 32'(dbg_data), 0);
    end

    issue(enc(5'd17, 1'b1, 3'd1, 3'd0, 8'd0), 8'd1, 3'd0, 1'b0, 3'd1, 20'd1, 3'd1, 20'd1);
    issue(enc(5'd6, 1'b0, 3'd0, 3'd0, 8'h07), 8'd2, 3'd7, 1'b0, 3'd1, 20'd1, 3'd1, 20'd1);
    wait_ready();
    bus.instr_valid = 1'b1;
    bus.instr = enc(5'd19, 1'b1, 3'd1, 3'd1, 8'd0);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("add_exec_op", 32'(bus.alu_op), 19);
    chk("add_exec_a", 32'(bus.alu_a), 1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_pc", 32'(pc), 0);
    chk("abort_status", 32'(status), 0);
    chk("abort_busy", 32'(busy), 0);
    stim_addr = 3'd1;
    #1 chk("abort_R1", 32'(dbg_data), 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
